// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter sharing one data load/store port, fixed wait states per access.
// Optional ARB_LOCK_EN adds m0_lock/m1_lock so the last-granted master can hold the port for atomic sequences.
module dmem_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic          last, win, lat_we, locked, grant, pick;

`ifdef ARB_LOCK_EN
    assign locked = last ? m1_lock : m0_lock;
`else
    assign locked = 1'b0;
`endif

    // A held lock pins the choice to the previous owner; otherwise round-robin on contention.
    always_comb begin
        pick = locked ? last : (m0_req && m1_req) ? !last : m1_req;
        grant = locked ? (last ? m1_req : m0_req) : (m0_req || m1_req);
        next_state = state;
        unique case (state)
            IDLE:    next_state = grant ? ACCESS : IDLE;
            ACCESS:  next_state = (cnt == '0) ? DONE : ACCESS;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are gated by reset so an access interrupted by reset never emits a write or ack.
    always_comb begin
        busy = !reset && state != IDLE;
        mem_we = !reset && state == ACCESS && cnt == '0 && lat_we;
        m0_ack = !reset && state == DONE && !win;
        m1_ack = !reset && state == DONE && win;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: if (grant) begin
                    win       <= pick;
                    lat_we    <= pick ? m1_we : m0_we;
                    mem_addr  <= pick ? m1_addr : m0_addr;
                    mem_wdata <= pick ? m1_wdata : m0_wdata;
                    cnt       <= CNT_INIT;
                end
                ACCESS: if (cnt == '0) begin
                    if (win) m1_rdata <= mem_rdata;
                    else m0_rdata <= mem_rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE:    last <= win;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, contention/lock sequences and random traffic checked against a transaction-level model.
module tb_dmem_arbiter;
    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic        m0_ack, m1_ack, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;

    int errors = 0, checks = 0, cyc = 0;
    int ack_who[$], ack_cyc[$];

    // Reference model: phase counts cycles since grant (0 = idle, 1..WS access, WS+1 done).
    int          ph = 0;
    logic        mlast = 1'b1, mwin = 1'b0, mwe = 1'b0;
    logic [31:0] maddr = '0, mwdata = '0, mrd0 = '0, mrd1 = '0;

    dmem_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic grant_to(input logic w);
        mwin = w;
        mwe = w ? m1_we : m0_we;
        maddr = w ? m1_addr : m0_addr;
        mwdata = w ? m1_wdata : m0_wdata;
        ph = 1;
    endtask

    task automatic step();
        logic lk;
        #1;
        chk("busy", 32'(busy), 32'(!reset && ph != 0));
        chk("mem_we", 32'(mem_we), 32'(!reset && ph == WS && mwe));
        chk("m0_ack", 32'(m0_ack), 32'(!reset && ph == WS + 1 && !mwin));
        chk("m1_ack", 32'(m1_ack), 32'(!reset && ph == WS + 1 && mwin));
        if (!reset) begin
            chk("m0_rdata", m0_rdata, mrd0);
            chk("m1_rdata", m1_rdata, mrd1);
            chk("mem_addr", mem_addr, maddr);
            chk("mem_wdata", mem_wdata, mwdata);
        end
        if (m0_ack || m1_ack) begin
            ack_who.push_back(m1_ack ? 1 : 0);
            ack_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (reset) begin
            ph = 0; mlast = 1'b1; mrd0 = '0; mrd1 = '0; maddr = '0; mwdata = '0;
        end else if (ph == 0) begin
            lk = mlast ? m1_lock : m0_lock;
            if (lk) begin
                if (mlast ? m1_req : m0_req) grant_to(mlast);
            end else if (m0_req && m1_req) grant_to(!mlast);
            else if (m0_req) grant_to(1'b0);
            else if (m1_req) grant_to(1'b1);
        end else if (ph == WS) begin
            if (mwin) mrd1 = mem_rdata;
            else mrd0 = mem_rdata;
            ph++;
        end else if (ph == WS + 1) begin
            mlast = mwin;
            ph = 0;
        end else ph++;
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  c;    // {reset, m0_req, m0_we, m1_req, m1_we}
        logic [31:0] a0, d0, a1, d1, rd;
        logic [3:0]  e;    // {m0_ack, m1_ack, mem_we, busy}
    } vec_t;

    initial begin
        vec_t tbl[$];
        int n, rel;
        tbl.push_back('{5'b11011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0000});
        tbl.push_back('{5'b11011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0000});
        tbl.push_back('{5'b01011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0000});
        tbl.push_back('{5'b01011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0001});
        tbl.push_back('{5'b01011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0001});
        tbl.push_back('{5'b01011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 4'b0001});
        tbl.push_back('{5'b00011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b1001});
        tbl.push_back('{5'b00011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0000});
        tbl.push_back('{5'b00011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0001});
        tbl.push_back('{5'b00011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0001});
        tbl.push_back('{5'b00011, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0011});
        tbl.push_back('{5'b00000, 32'h8004, 32'h0, 32'h1000_0000, 32'h1234_5678, 32'h0, 4'b0101});
        tbl.push_back('{5'b01100, 32'h20, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 4'b0000});
        tbl.push_back('{5'b00000, 32'h20, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 4'b0001});
        tbl.push_back('{5'b10000, 32'h20, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 4'b0000});
        tbl.push_back('{5'b00000, 32'h20, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 4'b0000});
        tbl.push_back('{5'b00000, 32'h20, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 4'b0000});

        foreach (tbl[i]) begin
            {reset, m0_req, m0_we, m1_req, m1_we} = tbl[i].c;
            m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
            m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
            mem_rdata = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d_acks_we_busy", i), 32'({m0_ack, m1_ack, mem_we, busy}), 32'(tbl[i].e));
            if (i == 6) chk("vec6_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
            if (i == 10) chk("vec10_wr_addr", mem_addr, 32'h1000_0000);
            if (i == 10) chk("vec10_wr_data", mem_wdata, 32'h1234_5678);
            step();
        end

        // Continuous contention: strict alternation starting with m0, fixed spacing.
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        n = ack_who.size();
        for (int i = 0; i < 80 && ack_who.size() < n + 4; i++) begin
            mem_rdata = $urandom;
            step();
        end
        chk("contention_ack_count", ack_who.size(), n + 4);
        for (int k = 0; k < 4 && n + k < ack_who.size(); k++) begin
            chk($sformatf("contention_order%0d", k), ack_who[n+k], k % 2);
            if (k > 0) chk($sformatf("contention_gap%0d", k), ack_cyc[n+k] - ack_cyc[n+k-1], WS + 2);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (WS + 3) step();

`ifdef ARB_LOCK_EN
        reset = 1'b1; step(); reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1;
        n = ack_who.size();
        for (int i = 0; i < 40 && ack_who.size() < n + 2; i++) begin
            if (ack_who.size() == n + 1) m1_we = 1'b1;
            mem_rdata = $urandom;
            step();
        end
        chk("lock_m1_acks", ack_who.size(), n + 2);
        for (int k = 0; k < 2 && n + k < ack_who.size(); k++) chk($sformatf("lock_owner%0d", k), ack_who[n+k], 1);
        m1_req = 1'b0;
        repeat (3) step();
        chk("lock_holds_port", ack_who.size(), n + 2);
        m1_lock = 1'b0;
        rel = cyc;
        for (int i = 0; i < 20 && ack_who.size() < n + 3; i++) step();
        chk("lock_release_ack", ack_who.size(), n + 3);
        if (ack_who.size() > n + 2) begin
            chk("lock_release_who", ack_who[n+2], 0);
            chk("lock_release_latency", ack_cyc[n+2] - rel, WS + 1);
        end
        m0_req = 1'b0;
        repeat (WS + 3) step();
`endif

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            m0_req = ($urandom_range(0, 2) != 0); m0_we = $urandom_range(0, 1) == 1;
            m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1) == 1;
            m0_addr = $urandom; m0_wdata = $urandom;
            m1_addr = $urandom; m1_wdata = $urandom;
            mem_rdata = $urandom;
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
